motoro3_pwm_sequencer: RTL

//  Period/duty scheduler for the 3-phase motor PWM generator. Owns the PWM period counter and emits
//  the one-clock period-end strobe. Ramps the on-time request toward a target once per period,

---
 rtl/motoro3_pwm_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/motoro3_pwm_sequencer.sv
// -----------------------------------------------------------------------------
// motoro3_pwm_sequencer
// Period/duty scheduler for the 3-phase motor PWM generator.
//  - Owns the PWM period counter and emits a one-clock strobe (o_periodLast)
//    on the last clock of every period.
//  - Once per period (on the tick, the edge where the counter goes 1->0) it
//    ramps the on-time toward the target and publishes it on o_pwmLenWant,
//    applying min-on masking, period clamp, soft start and emergency brake.
//
// Optional feature macro: M3_PWM_SOFTSTOP_EN
//  defined   : dropping i_enable enters STOP and ramps down by i_rampStep/period
//  undefined : dropping i_enable forces duty 0 and IDLE at the next tick
//
// Ports
//  i_clk         in   1         system clock, posedge
//  nRst          in   1         asynchronous active-low reset
//  i_enable      in   1         run request (level)
//  i_brake       in   1         emergency stop (level, highest priority)
//  i_periodLen   in   PERIOD_W  clocks per PWM period
//  i_dutyTarget  in   DUTY_W    requested on-time
//  i_dutyMin     in   DUTY_W    minimum on-time; smaller duty is output as 0
//  i_rampStep    in   DUTY_W    duty change per period (0 = jump to target)
//  o_periodLast  out  1         strobe on last clock of each period
//  o_pwmLenWant  out  DUTY_W    on-time for the period following the strobe
//  o_state       out  2         0 IDLE, 1 RAMP, 2 HOLD, 3 STOP
//  o_busy        out  1         state != IDLE
// -----------------------------------------------------------------------------
module motoro3_pwm_sequencer #(
  parameter int PERIOD_W   = 16,
  parameter int DUTY_W     = 12,
  parameter int MIN_PERIOD = 2
) (
  input  logic                i_clk,
  input  logic                nRst,
  input  logic                i_enable,
  input  logic                i_brake,
  input  logic [PERIOD_W-1:0] i_periodLen,
  input  logic [DUTY_W-1:0]   i_dutyTarget,
  input  logic [DUTY_W-1:0]   i_dutyMin,
  input  logic [DUTY_W-1:0]   i_rampStep,
  output logic                o_periodLast,
  output logic [DUTY_W-1:0]   o_pwmLenWant,
  output logic [1:0]          o_state,
  output logic                o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_HOLD = 2'd2,
    S_STOP = 2'd3
  } state_t;

  localparam logic [PERIOD_W-1:0] LP_MIN_PER = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] LP_ONE     = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [DUTY_W-1:0]   LP_DZERO   = {DUTY_W{1'b0}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PERIOD_W-1:0] r_perCnt;
  logic [PERIOD_W-1:0] r_perLen;
  logic [DUTY_W-1:0]   r_dutyCur;
  logic [DUTY_W-1:0]   w_duty_nxt;
  logic [DUTY_W-1:0]   w_pwm_nxt;
  logic [PERIOD_W-1:0] w_perLenEff;
  logic [PERIOD_W-1:0] w_perMax;
  logic [DUTY_W-1:0]   w_tgt;
  logic [DUTY_W-1:0]   w_stepTgt;
  logic [DUTY_W-1:0]   w_stepZero;
  logic [DUTY_W-1:0]   w_stepFirst;
  logic                w_reload;
  logic                w_tick;

  // One ramp step from cur toward x; the distance compare guarantees no wrap.
  function automatic logic [DUTY_W-1:0] f_step(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] x,
    input logic [DUTY_W-1:0] step
  );
    logic [DUTY_W-1:0] diff;
    diff = (x >= cur) ? (x - cur) : (cur - x);
    if ((step == LP_DZERO) || (diff <= step)) begin
      f_step = x;
    end else if (x > cur) begin
      f_step = cur + step;
    end else begin
      f_step = cur - step;
    end
  endfunction

  assign w_perLenEff = (i_periodLen < LP_MIN_PER) ? LP_MIN_PER : i_periodLen;
  assign w_reload    = (r_perCnt == {PERIOD_W{1'b0}});
  assign w_tick      = (r_perCnt == LP_ONE);
  // Target is clamped against the period currently running, not the live input.
  assign w_perMax    = r_perLen - LP_ONE;
  assign w_tgt       = (PERIOD_W'(i_dutyTarget) <= w_perMax) ? i_dutyTarget
                                                             : DUTY_W'(w_perMax);
  assign w_stepTgt   = f_step(r_dutyCur, w_tgt, i_rampStep);
  assign w_stepZero  = f_step(r_dutyCur, LP_DZERO, i_rampStep);
  assign w_stepFirst = f_step(LP_DZERO, w_tgt, i_rampStep);

  // State register.
  always_ff @(posedge i_clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next duty; brake overrides, otherwise only ticks change anything.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_dutyCur;
    if (i_brake) begin
      w_state_nxt = S_IDLE;
      w_duty_nxt  = LP_DZERO;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            w_duty_nxt  = w_stepFirst;
            w_state_nxt = (w_stepFirst == w_tgt) ? S_HOLD : S_RAMP;
          end else begin
            w_duty_nxt  = LP_DZERO;
            w_state_nxt = S_IDLE;
          end
        end
        S_RAMP, S_HOLD: begin
          if (!i_enable) begin
`ifdef M3_PWM_SOFTSTOP_EN
            w_duty_nxt  = w_stepZero;
            w_state_nxt = (w_stepZero == LP_DZERO) ? S_IDLE : S_STOP;
`else
            w_duty_nxt  = LP_DZERO;
            w_state_nxt = S_IDLE;
`endif
          end else begin
            // HOLD with unchanged target steps onto itself and stays in HOLD.
            w_duty_nxt  = w_stepTgt;
            w_state_nxt = (w_stepTgt == w_tgt) ? S_HOLD : S_RAMP;
          end
        end
        S_STOP: begin
`ifdef M3_PWM_SOFTSTOP_EN
          if (i_enable) begin
            w_state_nxt = S_RAMP;
          end else begin
            w_duty_nxt  = w_stepZero;
            w_state_nxt = (w_stepZero == LP_DZERO) ? S_IDLE : S_STOP;
          end
`else
          // Not reachable without soft stop; recover to a safe state.
          w_duty_nxt  = LP_DZERO;
          w_state_nxt = S_IDLE;
`endif
        end
        default: begin
          w_duty_nxt  = LP_DZERO;
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
      w_duty_nxt  = r_dutyCur;
    end
  end

  assign w_pwm_nxt = (w_duty_nxt < i_dutyMin) ? LP_DZERO : w_duty_nxt;

  // Period counter, strobe and duty registers.
  always_ff @(posedge i_clk or negedge nRst) begin
    if (!nRst) begin
      r_perCnt     <= {PERIOD_W{1'b0}};
      r_perLen     <= LP_MIN_PER;
      r_dutyCur    <= LP_DZERO;
      o_periodLast <= 1'b0;
      o_pwmLenWant <= LP_DZERO;
      o_busy       <= 1'b0;
    end else begin
      if (i_brake || w_reload) begin
        r_perCnt <= w_perLenEff - LP_ONE;
        r_perLen <= w_perLenEff;
      end else begin
        r_perCnt <= r_perCnt - LP_ONE;
        r_perLen <= r_perLen;
      end
      o_periodLast <= w_tick && !i_brake;
      r_dutyCur    <= w_duty_nxt;
      if (i_brake || w_tick) begin
        o_pwmLenWant <= w_pwm_nxt;
      end else begin
        o_pwmLenWant <= o_pwmLenWant;
      end
      o_busy <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_state = r_state;

endmodule
